mdu_sched: RTL and testbench

//   Multiply/divide unit scheduler for the 5-stage pipeline. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO

---
 rtl/mdu_sched_if.sv | 23 ++
 rtl/mdu_sched.sv | 122 ++++++++++++
 tb/tb_mdu_sched.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mdu_sched_if.sv
// E/D-stage side of the multiply/divide scheduler: op request, operands, stall query
// and the architectural HI/LO it owns.
interface mdu_sched_if;
  logic [2:0]  E_MD_Op;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        D_MD_Use;
  logic        Start;
  logic        Busy;
  logic        MD_Stall;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output E_MD_Op, E_A, E_B, D_MD_Use,
    input  Start, Busy, MD_Stall, HI, LO
  );

  modport slave (
    input  E_MD_Op, E_A, E_B, D_MD_Use,
    output Start, Busy, MD_Stall, HI, LO
  );
endinterface

// File: rtl/mdu_sched.sv
// Multiply/divide scheduler: computes MULT/DIV results at issue, holds them pending for a
// fixed busy period, then commits to HI/LO. Stalls D while an MD instruction would race it.
module mdu_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  mdu_sched_if.slave  md
);
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      state, state_nxt;
  logic [3:0]  count;
  logic [31:0] hi, lo, pend_hi, pend_lo;
  logic        is_mul, is_div, sgn, start, busy;

  logic [63:0] ext_a, ext_b, product;
  logic        neg_a, neg_b, div_zero;
  logic [31:0] mag_a, mag_b, div_b, q_mag, r_mag, quot, rem;
  logic [31:0] res_hi, res_lo;

  always_comb begin
    is_mul = (md.E_MD_Op == OP_MULT) || (md.E_MD_Op == OP_MULTU);
    is_div = (md.E_MD_Op == OP_DIV)  || (md.E_MD_Op == OP_DIVU);
    sgn    = (md.E_MD_Op == OP_MULT) || (md.E_MD_Op == OP_DIV);
  end

  // One 64-bit multiplier serves both: sign-extending for MULT gives the
  // two's-complement product in the low 64 bits.
  always_comb begin
    ext_a   = {{32{sgn & md.E_A[31]}}, md.E_A};
    ext_b   = {{32{sgn & md.E_B[31]}}, md.E_B};
    product = ext_a * ext_b;
  end

  // Signed divide through magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
  always_comb begin
    neg_a    = sgn & md.E_A[31];
    neg_b    = sgn & md.E_B[31];
    mag_a    = neg_a ? -md.E_A : md.E_A;
    mag_b    = neg_b ? -md.E_B : md.E_B;
    div_zero = (md.E_B == 32'd0);
    div_b    = div_zero ? 32'd1 : mag_b;
    q_mag    = mag_a / div_b;
    r_mag    = mag_a % div_b;
    quot     = (neg_a ^ neg_b) ? -q_mag : q_mag;
    rem      = neg_a ? -r_mag : r_mag;
  end

  // Divide by zero commits the current HI/LO, so the registers look untouched.
  always_comb begin
    res_hi = hi;
    res_lo = lo;
    if (is_mul) begin
      res_hi = product[63:32];
      res_lo = product[31:0];
    end else if (is_div && !div_zero) begin
      res_hi = rem;
      res_lo = quot;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start)         state_nxt = S_BUSY;
      S_BUSY: if (count == 4'd1) state_nxt = S_IDLE;
      default:                   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    start = (is_mul || is_div) && (state == S_IDLE);
    busy  = (state == S_BUSY);
  end

  // Ops arriving while busy are dropped: only the IDLE branch looks at E_MD_Op.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= 4'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else if (state == S_IDLE) begin
      if (start) begin
        count   <= is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
        pend_hi <= res_hi;
        pend_lo <= res_lo;
      end else if (md.E_MD_Op == OP_MTHI) begin
        hi <= md.E_A;
      end else if (md.E_MD_Op == OP_MTLO) begin
        lo <= md.E_A;
      end
    end else begin
      count <= count - 4'd1;
      if (count == 4'd1) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end
  end

  assign md.Start    = start;
  assign md.Busy     = busy;
  assign md.MD_Stall = md.D_MD_Use & (start | busy);
  assign md.HI       = hi;
  assign md.LO       = lo;
endmodule

// File: tb/tb_mdu_sched.sv
// Bench for mdu_sched: table of MD ops with hand-computed HI/LO and busy length,
// stall/reset sequences, and a random run checked every cycle against a behavioural model.
module tb_mdu_sched;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_sched_if md ();
  mdu_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (.clk(clk), .reset(reset), .md(md));

  int total_cnt = 0;
  int pass_cnt  = 0;

  // behavioural model: architectural HI/LO, cycles left, result waiting to land
  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  int          m_left = 0;
  logic        s_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  task automatic calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] rh, output logic [31:0] rl);
    longint sa, sb, q, r;
    logic [63:0] p;
    rh = m_hi; rl = m_lo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin p = 64'(sa * sb); rh = p[63:32]; rl = p[31:0]; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; rh = p[63:32]; rl = p[31:0]; end
      3'd3: if (b != 0) begin q = sa / sb; r = sa % sb; rh = r[31:0]; rl = q[31:0]; end
      3'd4: if (b != 0) begin rh = a % b; rl = a / b; end
      default: ;
    endcase
  endtask

  // Compare all outputs at negedge against the model, then advance the model across the edge.
  task automatic step(output logic b);
    logic e_start, e_busy;
    @(negedge clk);
    e_start = (m_left == 0) && (md.E_MD_Op >= 3'd1) && (md.E_MD_Op <= 3'd4);
    e_busy  = (m_left > 0);
    chk("start", md.Start, e_start);
    chk("busy",  md.Busy,  e_busy);
    chk("stall", md.MD_Stall, md.D_MD_Use & (e_start | e_busy));
    chk("hi",    md.HI, m_hi);
    chk("lo",    md.LO, m_lo);
    b = md.Busy;
    s_stall = md.MD_Stall;
    if (reset) begin
      m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_hi = m_phi; m_lo = m_plo; end
    end else if (e_start) begin
      m_left = (md.E_MD_Op <= 3'd2) ? MC : DC;
      calc(md.E_MD_Op, md.E_A, md.E_B, m_phi, m_plo);
    end else if (md.E_MD_Op == 3'd5) m_hi = md.E_A;
    else if (md.E_MD_Op == 3'd6) m_lo = md.E_A;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [31:0] hi, lo;
    int          cyc;
  } vec_t;

  vec_t vt[$];
  logic bsy;
  int   n;

  initial begin
    vt.push_back('{3'd1, 32'h3,        32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFF4, 5});
    vt.push_back('{3'd4, 32'h7,        32'h2,        32'h1,        32'h3,        10});
    vt.push_back('{3'd3, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10});
    vt.push_back('{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5});
    vt.push_back('{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 10});
    vt.push_back('{3'd3, 32'h5,        32'h0,        32'h0,        32'h80000000, 10});
    vt.push_back('{3'd4, 32'd100,      32'd7,        32'd2,        32'd14,       10});
    vt.push_back('{3'd5, 32'h12345678, 32'h0,        32'h12345678, 32'd14,       0});
    vt.push_back('{3'd6, 32'hCAFEF00D, 32'h0,        32'h12345678, 32'hCAFEF00D, 0});
    vt.push_back('{3'd3, 32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 10});
    vt.push_back('{3'd4, 32'h9,        32'h0,        32'h1,        32'hFFFFFFFD, 10});

    reset = 1'b1;
    md.E_MD_Op = 3'd0; md.E_A = '0; md.E_B = '0; md.D_MD_Use = 1'b0;
    @(posedge clk); #1;
    step(bsy);
    reset = 1'b0;
    step(bsy);

    foreach (vt[i]) begin
      md.E_MD_Op = vt[i].op; md.E_A = vt[i].a; md.E_B = vt[i].b;
      step(bsy);
      md.E_MD_Op = 3'd0;
      n = 0;
      for (int k = 0; k < 20; k++) begin
        step(bsy);
        if (!bsy) break;
        n++;
      end
      chk($sformatf("v%0d_busy_cycles", i), n, vt[i].cyc);
      chk($sformatf("v%0d_hi", i), md.HI, vt[i].hi);
      chk($sformatf("v%0d_lo", i), md.LO, vt[i].lo);
    end

    // MULT with an MFLO waiting in D: stall covers start + busy period only
    md.D_MD_Use = 1'b1;
    md.E_MD_Op = 3'd1; md.E_A = 32'd5; md.E_B = 32'd6;
    n = 0;
    step(bsy);
    if (s_stall) n++;
    md.E_MD_Op = 3'd0;
    for (int k = 0; k < 20; k++) begin
      step(bsy);
      if (!s_stall) break;
      n++;
    end
    chk("stall_cycles", n, MC + 1);
    chk("mflo_after_stall", md.LO, 32'd30);

    // DIVU aborted by reset during its 4th busy cycle
    md.E_MD_Op = 3'd4; md.E_A = 32'd100; md.E_B = 32'd3;
    step(bsy);
    md.E_MD_Op = 3'd0;
    repeat (3) step(bsy);
    reset = 1'b1;
    step(bsy);
    reset = 1'b0;
    chk("rst_abort_busy",  md.Busy, 1'b0);
    chk("rst_abort_hi",    md.HI, 32'd0);
    chk("rst_abort_lo",    md.LO, 32'd0);
    chk("rst_abort_stall", md.MD_Stall, 1'b0);
    step(bsy);
    md.D_MD_Use = 1'b0;

    // random ops including ones that land while busy (must be ignored)
    for (int k = 0; k < 400; k++) begin
      md.E_MD_Op  = 3'($urandom_range(0, 7));
      md.E_A      = $urandom;
      md.E_B      = ($urandom_range(0, 7) == 0) ? 32'd0 :
                    ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      if ($urandom_range(0, 9) == 0) md.E_A = 32'h80000000;
      md.D_MD_Use = 1'($urandom_range(0, 1));
      step(bsy);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
